pb_bounce_emulator: RTL and testbench
=====================================

// Module: pb_bounce_emulator
// PURPOSE
//  Drives an active-low, bouncing push-button line: the transmit end of the 1 kHz shift-register debouncer.
//  On a start pulse it plays one press: press bounce, stable hold, release bounce, then a done pulse.
//  Used as the stimulus source for the debouncer and counter control path, on the bench and on the board.
//  Bounce pattern comes from a seeded LFSR, so waveforms repeat exactly after every reset.
// PARAMETERS
//  TICK_DIV    50000     CLOCK_50_I cycles per 1 ms phase tick (1 kHz at 50 MHz).
//  BOUNCE_DIV  500       cycles per bounce sample (10 us); BOUNCE_DIV must divide TICK_DIV.
//  BOUNCE_MS   4         length of each bounce phase, in ms ticks (1..15).
//  LFSR_SEED   16'hACE1  LFSR value loaded on reset; must be nonzero.
// PORTS
//  CLOCK_50_I       in   1   Clock, 50 MHz.
//  RESET_I          in   1   Synchronous, active-high reset.
//  start_i          in   1   Request one press; sampled while in IDLE only.
//  hold_ms_i        in   10  Stable-low hold time in ms; latched on start; 0 is treated as 1.
//  busy_o           out  1   High in every state except IDLE.
//  done_o           out  1   One-cycle pulse in the DONE state.
//  PUSH_BUTTON_N_O  out  1   Emulated button line; 1 = released, 0 = pressed.
// BEHAVIOUR
//  Reset: state=IDLE; PUSH_BUTTON_N_O=1; busy_o=0; done_o=0; counters=0; lfsr=LFSR_SEED; hold_q=0.
//  FSM: IDLE -> B_PRESS -> HELD -> B_RELEASE -> DONE -> IDLE. All outputs are registered.
//  IDLE: output is 1. start_i=1 latches hold_q = max(hold_ms_i,1). The next cycle enters B_PRESS with busy_o=1.
//  Phase timer: the cycle counter and ms counter clear on every state entry, so phases last exactly:
//   - B_PRESS and B_RELEASE: BOUNCE_MS*TICK_DIV cycles each.
//   - HELD: hold_q*TICK_DIV cycles.
//  Bounce tick: pulses when the cycle counter mod BOUNCE_DIV == BOUNCE_DIV-1. The LFSR advances only on bounce ticks.
//  B_PRESS and B_RELEASE: output <= lfsr[0] on each bounce tick; it changes only on bounce ticks.
//  Phase entry values: the first cycle of B_PRESS drives 0; the first cycle of B_RELEASE drives 1.
//  HELD: output 0. DONE: output 1, done_o=1, busy_o=1 for exactly one cycle, then IDLE.
//  start_i outside IDLE, including the DONE cycle, is ignored (no queueing).
//  hold_ms_i changes after start have no effect; only hold_q is used.
//  Reset mid-operation: the next cycle is the reset state, with no done_o and the LFSR reseeded.
//  LFSR: 16-bit Galois, taps 16'hB400; shifts right and XORs taps when the bit shifted out is 1.
//  Width rules: the ms counter is 10 bits, compared to hold_q or BOUNCE_MS; the cycle counter is $clog2(TICK_DIV) bits and wraps to 0 at TICK_DIV-1.
// CONFIGURATION
//  PB_EMU_GLITCH_EN defined:
//   - In HELD, on each bounce tick with lfsr[3:0]==4'h0, output is 1 for exactly BOUNCE_DIV cycles, then 0 again.
//   - This exercises the OR-of-10-samples filter in the debouncer.
//   - The HELD length is unchanged.
//  Not defined: HELD is a constant 0, and the LFSR still advances on bounce ticks in HELD.
//   - Bounce patterns therefore match between the two builds.
// STRUCTURE
//  pb_emu_pkg:
//   - typedef enum logic[2:0] pb_emu_state_t {S_IDLE,S_B_PRESS,S_HELD,S_B_RELEASE,S_DONE}.
//   - localparam LFSR_TAPS=16'hB400; default TICK_DIV/BOUNCE_DIV constants.
//  Sub-module lfsr16 (clk, reset, load seed, advance enable, 16-bit state out).
//  The top holds the FSM, the two counters and the output register.
// TESTING (bench params TICK_DIV=50, BOUNCE_DIV=5, BOUNCE_MS=4)
//  1. RESET_I=1 for 3 cycles -> PUSH_BUTTON_N_O=1, busy_o=0, done_o=0; hold start_i=0 for 100 cycles -> no change.
//  2. start_i pulse, hold_ms_i=10 -> busy_o=1 next cycle; bounce 200 cycles with toggles only every 5th cycle;
//     then 0 for 500 cycles; bounce 200 cycles; done_o high on cycle 901 after start; busy_o=0 on cycle 902.
//  3. hold_ms_i=0 -> HELD lasts 50 cycles; start_i during HELD and during DONE -> ignored, only one done_o.
//  4. RESET_I asserted at cycle 300 (in HELD) -> cycle 301: output 1, busy_o=0, no done_o; a new start replays an identical bounce.
//  5. Two runs after reset -> bit-identical waveforms; the first B_PRESS samples match the lfsr16 model from 16'hACE1.
//  6. PB_EMU_GLITCH_EN -> HELD shows 1-pulses of exactly 5 cycles where the model predicts them; without the macro, HELD is flat 0.

Source files
------------

// File: rtl/pb_bounce_emulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pb_emu_pkg
// Description : Shared types and constants for the push-button bounce
//               emulator: FSM state encoding, LFSR tap mask and default
//               clock-divider constants.
// Revision    : 1.0 - initial release
// ============================================================================
package pb_emu_pkg;

  // One press is played as IDLE -> B_PRESS -> HELD -> B_RELEASE -> DONE.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_B_PRESS   = 3'd1,
    S_HELD      = 3'd2,
    S_B_RELEASE = 3'd3,
    S_DONE      = 3'd4
  } pb_emu_state_t;

  // Galois feedback mask applied when the bit shifted out is 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // 1 ms phase tick and 10 us bounce sample at a 50 MHz clock.
  localparam int DEF_TICK_DIV   = 50000;
  localparam int DEF_BOUNCE_DIV = 500;

endpackage
`default_nettype wire

// File: rtl/pb_bounce_emulator_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : 16-bit right-shifting Galois LFSR. Loads SEED on reset or on
//               i_load, advances one step when i_adv is high.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
  import pb_emu_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_adv,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  // Seed on reset/load, otherwise shift right and fold in the taps when a 1 drops out.
  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_state <= SEED;
    end else if (i_adv) begin
      r_state <= (r_state >> 1) ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/pb_bounce_emulator.sv
`default_nettype none
// ============================================================================
// Module      : pb_bounce_emulator
// Description : Plays one bouncing, active-low button press per start pulse:
//               press bounce, stable hold, release bounce, done pulse.
//               Bounce samples come from a seeded LFSR so every run after a
//               reset is identical.
// Options     : PB_EMU_GLITCH_EN - inject BOUNCE_DIV-long release glitches
//               into the held-low phase.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_bounce_emulator
  import pb_emu_pkg::*;
#(
  parameter int          TICK_DIV   = DEF_TICK_DIV,
  parameter int          BOUNCE_DIV = DEF_BOUNCE_DIV,
  parameter int          BOUNCE_MS  = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       CLOCK_50_I,
  input  logic       RESET_I,
  input  logic       start_i,
  input  logic [9:0] hold_ms_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       PUSH_BUTTON_N_O
);

  localparam int              c_cw          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cw-1:0] c_tick_last   = c_cw'(TICK_DIV - 1);
  localparam logic [c_cw-1:0] c_bdiv        = c_cw'(BOUNCE_DIV);
  localparam logic [c_cw-1:0] c_bdiv_last   = c_cw'(BOUNCE_DIV - 1);
  localparam logic [c_cw-1:0] c_cyc_one     = c_cw'(1);
  localparam logic [9:0]      c_bounce_ms   = 10'(BOUNCE_MS);

  pb_emu_state_t   r_state;
  pb_emu_state_t   w_state_nxt;
  logic [c_cw-1:0] r_cyc;
  logic [9:0]      r_ms;
  logic [9:0]      r_hold;
  logic [9:0]      w_hold_nxt;
  logic [9:0]      w_limit;
  logic            r_pb;
  logic            w_pb_nxt;
  logic            r_busy;
  logic            w_busy_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            w_running;
  logic            w_cyc_wrap;
  logic            w_phase_end;
  logic            w_btick;
  logic [15:0]     w_lfsr;
  logic            w_unused_lfsr;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (CLOCK_50_I),
    .rst     (RESET_I),
    .i_load  (1'b0),
    .i_adv   (w_btick),
    .o_state (w_lfsr)
  );

  // Sink for LFSR bits the output logic does not look at.
  assign w_unused_lfsr = ^w_lfsr[15:1];

  // Phase timing: counters run only in the three timed phases; a phase ends on
  // the last cycle of its final ms tick.
  always_comb begin
    w_running   = (r_state == S_B_PRESS) || (r_state == S_HELD) || (r_state == S_B_RELEASE);
    w_limit     = (r_state == S_HELD) ? r_hold : c_bounce_ms;
    w_cyc_wrap  = (r_cyc == c_tick_last);
    w_phase_end = w_cyc_wrap && (r_ms == (w_limit - 10'd1));
    w_btick     = w_running && ((r_cyc % c_bdiv) == c_bdiv_last);
  end

  // Next state and next registered outputs; entry values are applied on the
  // transition edge so the first cycle of each phase already shows them.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_pb_nxt    = r_pb;
    w_busy_nxt  = 1'b1;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        w_pb_nxt   = 1'b1;
        if (start_i) begin
          w_state_nxt = S_B_PRESS;
          w_hold_nxt  = (hold_ms_i == 10'd0) ? 10'd1 : hold_ms_i;
          w_busy_nxt  = 1'b1;
          w_pb_nxt    = 1'b0;
        end
      end
      S_B_PRESS: begin
        if (w_phase_end) begin
          w_state_nxt = S_HELD;
          w_pb_nxt    = 1'b0;
        end else if (w_btick) begin
          w_pb_nxt = w_lfsr[0];
        end
      end
      S_HELD: begin
        if (w_phase_end) begin
          w_state_nxt = S_B_RELEASE;
          w_pb_nxt    = 1'b1;
        end
`ifdef PB_EMU_GLITCH_EN
        else if (w_btick) begin
          w_pb_nxt = (w_lfsr[3:0] == 4'h0);
        end
`else
        else begin
          w_pb_nxt = 1'b0;
        end
`endif
      end
      S_B_RELEASE: begin
        if (w_phase_end) begin
          w_state_nxt = S_DONE;
          w_pb_nxt    = 1'b1;
          w_done_nxt  = 1'b1;
        end else if (w_btick) begin
          w_pb_nxt = w_lfsr[0];
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_pb_nxt    = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_pb_nxt    = 1'b1;
      end
    endcase
  end

  // State, latched hold time and registered outputs.
  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      r_state <= S_IDLE;
      r_hold  <= 10'd0;
      r_pb    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_pb    <= w_pb_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Cycle and ms counters; cleared outside timed phases and on every state change.
  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I || !w_running || (w_state_nxt != r_state)) begin
      r_cyc <= '0;
      r_ms  <= 10'd0;
    end else if (w_cyc_wrap) begin
      r_cyc <= '0;
      r_ms  <= r_ms + 10'd1;
    end else begin
      r_cyc <= r_cyc + c_cyc_one;
    end
  end

  assign PUSH_BUTTON_N_O = r_pb;
  assign busy_o          = r_busy;
  assign done_o          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pb_bounce_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pb_bounce_emulator
// Description : Self-checking bench for pb_bounce_emulator with a closed-form
//               waveform model (phase offsets plus a precomputed LFSR table).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_bounce_emulator;

  localparam int TD = 50;
  localparam int BD = 5;
  localparam int BM = 4;
  localparam int P  = BM * TD;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] hold;
  logic       busy;
  logic       done;
  logic       pb;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] seq [0:4095];
  logic        wave1 [0:1023];
  logic        wave2 [0:1023];

  int m_k     = 0;
  int m_hold  = 1;
  int m_base  = 0;
  bit m_en    = 1'b0;

  pb_bounce_emulator #(
    .TICK_DIV   (TD),
    .BOUNCE_DIV (BD),
    .BOUNCE_MS  (BM),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .CLOCK_50_I      (clk),
    .RESET_I         (rst),
    .start_i         (start),
    .hold_ms_i       (hold),
    .busy_o          (busy),
    .done_o          (done),
    .PUSH_BUTTON_N_O (pb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int total_len(input int h);
    return 2 * P + h * TD;
  endfunction

  // Expected line value k cycles after start, given the LFSR advance count at start.
  function automatic logic exp_pb(input int k, input int h, input int base);
    int hl;
    int j;
    hl = h * TD;
    if (k == 0) return 1'b1;
    if (k > 2 * P + hl) return 1'b1;
    if (k <= P) begin
      j = k - 1;
      if (j < BD) return 1'b0;
      return seq[base + j / BD - 1][0];
    end
    if (k <= P + hl) begin
`ifdef PB_EMU_GLITCH_EN
      j = k - 1 - P;
      if (j < BD) return 1'b0;
      return (seq[base + P / BD + j / BD - 1][3:0] == 4'h0);
`else
      return 1'b0;
`endif
    end
    j = k - 1 - P - hl;
    if (j < BD) return 1'b1;
    return seq[base + (P + hl) / BD + j / BD - 1][0];
  endfunction

  // Model position update on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    if (rst) begin
      m_k    = 0;
      m_base = 0;
      m_en   = 1'b1;
    end else if (m_k == 0) begin
      if (start) begin
        m_k    = 1;
        m_hold = (hold == 10'd0) ? 1 : int'(hold);
      end
    end else if (m_k == total_len(m_hold) + 1) begin
      m_base = m_base + total_len(m_hold) / BD;
      m_k    = 0;
    end else begin
      m_k = m_k + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_en) begin
      chk("model_pb", {31'd0, pb}, {31'd0, exp_pb(m_k, m_hold, m_base)});
      chk("model_busy", {31'd0, busy}, {31'd0, (m_k != 0)});
      chk("model_done", {31'd0, done}, {31'd0, (m_k == total_len(m_hold) + 1)});
    end
  end

  initial begin
    int ndone;
    int mism;
    int ones;
    logic [15:0] s;

    s = 16'hACE1;
    for (int i = 0; i < 4096; i++) begin
      seq[i] = s;
      s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    end

    // 1: reset and idle
    rst = 1'b1; start = 1'b0; hold = 10'd0;
    repeat (3) @(negedge clk);
    chk("rst_pb", {31'd0, pb}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("model_seq1", {16'd0, seq[1]}, 32'h0000E270);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_pb", {31'd0, pb}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 2: full press with hold 10 ms
    hold = 10'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0; hold = 10'd3;
    chk("t2_busy_k1", {31'd0, busy}, 32'd1);
    wave1[1] = pb;
    for (int k = 2; k <= 902; k++) begin
      @(negedge clk);
      wave1[k] = pb;
      if (k == 3)   chk("t2_pb_k3", {31'd0, pb}, 32'd0);
      if (k == 6)   chk("t2_pb_k6", {31'd0, pb}, 32'd1);
      if (k == 11)  chk("t2_pb_k11", {31'd0, pb}, 32'd0);
      if (k == 31)  chk("t2_pb_k31", {31'd0, pb}, 32'd1);
      if (k == 900) chk("t2_done_k900", {31'd0, done}, 32'd0);
      if (k == 901) chk("t2_done_k901", {31'd0, done}, 32'd1);
      if (k == 902) chk("t2_busy_k902", {31'd0, busy}, 32'd0);
    end

    // 3: hold 0 treated as 1 ms; starts during HELD and DONE are ignored
    hold = 10'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = (done === 1'b1) ? 1 : 0;
    for (int k = 2; k <= 470; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      if (k == 210) start = 1'b1;
      if (k == 211) start = 1'b0;
      if (k == 250) chk("t3_held_last", {31'd0, pb}, 32'd0);
      if (k == 251) chk("t3_release_entry", {31'd0, pb}, 32'd1);
      if (k == 451) begin
        chk("t3_done_k451", {31'd0, done}, 32'd1);
        start = 1'b1;
      end
      if (k == 452) begin
        chk("t3_busy_k452", {31'd0, busy}, 32'd0);
        start = 1'b0;
      end
      if (k == 460) chk("t3_busy_k460", {31'd0, busy}, 32'd0);
    end
    chk("t3_done_count", ndone, 32'd1);

    // 4: reset in HELD, then replay must match the first run
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold = 10'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mism = (pb !== wave1[1]) ? 1 : 0;
    for (int k = 2; k <= 300; k++) begin
      @(negedge clk);
      if (pb !== wave1[k]) mism++;
    end
    chk("t4_prefix_mismatches", mism, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_pb_after_rst", {31'd0, pb}, 32'd1);
    chk("t4_busy_after_rst", {31'd0, busy}, 32'd0);
    chk("t4_done_after_rst", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 5/6: full replay after reset is bit-identical; HELD content check
    hold = 10'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wave2[1] = pb;
    for (int k = 2; k <= 902; k++) begin
      @(negedge clk);
      wave2[k] = pb;
    end
    mism = 0;
    ones = 0;
    for (int k = 1; k <= 902; k++) begin
      if (wave1[k] !== wave2[k]) mism++;
      if (k >= 201 && k <= 700 && wave2[k] === 1'b1) ones++;
    end
    chk("t5_replay_mismatches", mism, 32'd0);
`ifdef PB_EMU_GLITCH_EN
    chk("t6_glitch_len_mod", ones % BD, 32'd0);
`else
    chk("t6_held_ones", ones, 32'd0);
`endif

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
